// File: rtl/adder_rom_2bit.sv
// adder_rom_2bit: 2-bit adder with carry-in. The result comes from a constant
// 32 x 3 lookup table addressed by {A, B, C}. Sum/Cout are combinational.
// Sum_q/Cout_q are the same result registered for synchronous consumers.
module adder_rom_2bit (
    output logic       Cout,
    output logic [1:0] Sum,
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       C,
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] Sum_q,
    output logic       Cout_q
);

    // ROM address: A[1] is the MSB, C is the LSB
    logic [4:0] w_addr;
    // ROM word: {carry, sum[1:0]} = A + B + C
    logic [2:0] w_word;

    logic [1:0] r_sum_q;
    logic       r_cout_q;

    assign w_addr = {A, B, C};

    // Constant lookup table. Each word is A + B + C for its address.
    always_comb begin
        // NOTE: w_word is given a value before the case, so no path leaves it
        // unassigned and no latch is inferred. Unknown X addresses stay unknown.
        w_word = 3'bxxx;
        case (w_addr)
            // A = 0
            5'd0:  w_word = 3'd0;
            5'd1:  w_word = 3'd1;
            5'd2:  w_word = 3'd1;
            5'd3:  w_word = 3'd2;
            5'd4:  w_word = 3'd2;
            5'd5:  w_word = 3'd3;
            5'd6:  w_word = 3'd3;
            5'd7:  w_word = 3'd4;
            // A = 1
            5'd8:  w_word = 3'd1;
            5'd9:  w_word = 3'd2;
            5'd10: w_word = 3'd2;
            5'd11: w_word = 3'd3;
            5'd12: w_word = 3'd3;
            5'd13: w_word = 3'd4;
            5'd14: w_word = 3'd4;
            5'd15: w_word = 3'd5;
            // A = 2
            5'd16: w_word = 3'd2;
            5'd17: w_word = 3'd3;
            5'd18: w_word = 3'd3;
            5'd19: w_word = 3'd4;
            5'd20: w_word = 3'd4;
            5'd21: w_word = 3'd5;
            5'd22: w_word = 3'd5;
            5'd23: w_word = 3'd6;
            // A = 3
            5'd24: w_word = 3'd3;
            5'd25: w_word = 3'd4;
            5'd26: w_word = 3'd4;
            5'd27: w_word = 3'd5;
            5'd28: w_word = 3'd5;
            5'd29: w_word = 3'd6;
            5'd30: w_word = 3'd6;
            5'd31: w_word = 3'd7;
            default: w_word = 3'bxxx;
        endcase
    end

    // NOTE: the table is pure constant logic, not storage, so reset never
    // touches it; the combinational outputs stay valid while rst_n is low.
    assign Cout = w_word[2];
    assign Sum  = w_word[1:0];

    // Registered copy of the lookup result, cleared by synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value, even when the inputs change on the same edge.
        if (!rst_n) begin
            r_sum_q  <= 2'b00;
            r_cout_q <= 1'b0;
        end else begin
            r_sum_q  <= w_word[1:0];
            r_cout_q <= w_word[2];
        end
    end

    assign Sum_q  = r_sum_q;
    assign Cout_q = r_cout_q;

endmodule

// File: tb/tb_adder_rom_2bit.sv
// Directed self-checking bench for adder_rom_2bit.
module tb_adder_rom_2bit;

    logic       clk;
    logic       rst_n;
    logic [1:0] A;
    logic [1:0] B;
    logic       C;
    logic [1:0] Sum;
    logic       Cout;
    logic [1:0] Sum_q;
    logic       Cout_q;

    int n_total;
    int n_bad;

    adder_rom_2bit dut (
        .Cout   (Cout),
        .Sum    (Sum),
        .A      (A),
        .B      (B),
        .C      (C),
        .clk    (clk),
        .rst_n  (rst_n),
        .Sum_q  (Sum_q),
        .Cout_q (Cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic c);
        A = a;
        B = b;
        C = c;
    endtask

    // Combinational check after settling
    task automatic comb(input string tag, input logic [1:0] a, input logic [1:0] b,
                        input logic c, input logic [1:0] exp_sum, input logic exp_cout);
        drive(a, b, c);
        #5;
        check({tag, "_sum"},  {6'd0, Sum},  {6'd0, exp_sum});
        check({tag, "_cout"}, {7'd0, Cout}, {7'd0, exp_cout});
    endtask

    // Pipeline stimulus: {A,B,C} and hand-computed {Cout,Sum}
    logic [4:0] p_vec [6];
    logic [2:0] p_exp [6];

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        drive(2'd0, 2'd0, 1'b0);

        p_vec[0] = {2'd1, 2'd2, 1'b1}; p_exp[0] = 3'd4;
        p_vec[1] = {2'd3, 2'd0, 1'b0}; p_exp[1] = 3'd3;
        p_vec[2] = {2'd2, 2'd3, 1'b1}; p_exp[2] = 3'd6;
        p_vec[3] = {2'd0, 2'd1, 1'b0}; p_exp[3] = 3'd1;
        p_vec[4] = {2'd3, 2'd2, 1'b0}; p_exp[4] = 3'd5;
        p_vec[5] = {2'd1, 2'd1, 1'b0}; p_exp[5] = 3'd2;

        // Combinational path, valid while reset is held
        comb("c120", 2'd1, 2'd2, 1'b0, 2'd3, 1'b0);
        comb("c221", 2'd2, 2'd2, 1'b1, 2'd1, 1'b1);
        comb("c000", 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        comb("c331", 2'd3, 2'd3, 1'b1, 2'd3, 1'b1);
        comb("c001", 2'd0, 2'd0, 1'b1, 2'd1, 1'b0);
        comb("c111", 2'd1, 2'd1, 1'b1, 2'd3, 1'b0);
        comb("c201", 2'd2, 2'd0, 1'b1, 2'd3, 1'b0);
        comb("c030", 2'd0, 2'd3, 1'b0, 2'd3, 1'b0);

        // Exhaustive sweep against plain arithmetic
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    logic [2:0] exp_word;
                    exp_word = 3'(a + b + c);
                    drive(2'(a), 2'(b), 1'(c));
                    #5;
                    check($sformatf("sweep_%0d%0d%0d", a, b, c),
                          {5'd0, Cout, Sum}, {5'd0, exp_word});
                end
            end
        end

        // Reset held: registers clear, combinational result unaffected
        @(negedge clk);
        rst_n = 1'b0;
        drive(2'd3, 2'd3, 1'b1);
        @(negedge clk);
        check("rst_sum_q",  {6'd0, Sum_q},  8'd0);
        check("rst_cout_q", {7'd0, Cout_q}, 8'd0);
        check("rst_sum",    {6'd0, Sum},    8'd3);
        check("rst_cout",   {7'd0, Cout},   8'd1);

        // First edge after release loads the lookup result
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_sum_q",  {6'd0, Sum_q},  8'd3);
        check("rel_cout_q", {7'd0, Cout_q}, 8'd1);

        // Pipeline: registered outputs trail inputs by one cycle
        {A, B, C} = p_vec[0];
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("pipe%0d", i - 1), {5'd0, Cout_q, Sum_q}, {5'd0, p_exp[i - 1]});
            {A, B, C} = p_vec[i];
        end
        @(negedge clk);
        check("pipe5", {5'd0, Cout_q, Sum_q}, {5'd0, p_exp[5]});

        // Reset asserted mid-stream clears on the next edge
        rst_n = 1'b0;
        drive(2'd3, 2'd3, 1'b1);
        @(negedge clk);
        check("mid_rst_q",    {5'd0, Cout_q, Sum_q}, 8'd0);
        check("mid_rst_comb", {5'd0, Cout, Sum},     8'd7);

        rst_n = 1'b1;
        drive(2'd2, 2'd1, 1'b0);
        @(negedge clk);
        check("post_rst_q", {5'd0, Cout_q, Sum_q}, 8'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_rom_2bit.md
# adder_rom_2bit

2-bit binary adder with carry-in, implemented as a 32-word × 3-bit read-only lookup table rather than gate-level full adders. It is a leaf arithmetic block. It provides an immediate (combinational) sum/carry result plus a registered copy for synchronous consumers.

## Interface
Parameters: none. All widths are fixed.

Ports (clock and reset first; positional order in RTL is Cout, Sum, A, B, C, clk, rst_n so positional instantiation of the first five ports works):
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous and active-low (sampled on rising clk edge)
- Cout  output  1  combinational carry-out = bit 2 of ROM word
- Sum  output  2  combinational sum = bits 1:0 of ROM word
- A  input  2  unsigned addend
- B  input  2  unsigned addend
- C  input  1  carry-in
- Sum_q  output  2  registered Sum
- Cout_q  output  1  registered Cout

## Operation
- ROM: 32 entries, 3 bits each.
  - Address = {A, B, C}, with A[1] as MSB and C as LSB.
  - Word = {Cout, Sum} = A + B + C as a 3-bit unsigned value (range 0..7).
- ROM contents are a constant table (case statement or initialized constant array). They are not writable and not affected by reset.
- Example words:
  - addr {1,2,0} → 3'b011
  - addr {2,2,1} → 3'b101
  - addr {3,3,1} → 3'b111
  - addr {0,0,0} → 3'b000
- Combinational path: Sum and Cout follow any change on A/B/C with no clock and no reset dependency. They are valid during reset and before the first clock edge.
- Registered path, on each rising clk edge:
  - rst_n = 0: Sum_q ← 2'b00, Cout_q ← 0.
  - otherwise: Sum_q ← Sum, Cout_q ← Cout.
- No X-propagation masking: X/Z on any input gives undefined combinational outputs. Registered outputs capture them as-is.
- No overflow condition beyond Cout. Max result 3+3+1 = 7 fits in {Cout, Sum}.

## Timing
- Combinational outputs: zero-cycle latency, pure propagation delay. They must settle well within 5 time units of an input change in behavioral simulation.
- Registered outputs: 1-cycle latency. The value captured is the one present at the rising edge.
- Reset values: Sum_q = 0, Cout_q = 0. Sum/Cout have no reset value; they always reflect the inputs.
- Reset asserted mid-operation: registered outputs clear on the next rising edge. The combinational outputs are unaffected.
- Reset deassertion: the first edge with rst_n = 1 loads the current lookup result.
- Simultaneous input change and clock edge: the register captures the pre-edge settled value (standard nonblocking semantics).

## Test plan
- Combinational, no clock: apply A=1, B=2, C=0, wait 5 → Sum=3, Cout=0. Then A=2, B=2, C=1 → Sum=1, Cout=1.
- Corners: A=0, B=0, C=0 → Sum=0, Cout=0. A=3, B=3, C=1 → Sum=3, Cout=1. A=0, B=0, C=1 → Sum=1, Cout=0.
- Mixed: A=1, B=1, C=1 → 3/0; A=2, B=0, C=1 → 3/0; A=0, B=3, C=0 → 3/0 (each as Sum/Cout).
- Exhaustive: sweep all 32 {A,B,C} → {Cout, Sum} == A+B+C for every address.
- Reset: hold rst_n=0 with A=3, B=3, C=1, then clock → Sum_q=0, Cout_q=0, while Sum=3, Cout=1. Release rst_n, then clock once → Sum_q=3, Cout_q=1.
- Pipeline: change the inputs every cycle → Sum_q/Cout_q equal the previous cycle's combinational result. Assert rst_n=0 mid-stream → zeros on the next edge.
